// File: rtl/hash_word_pager.sv
// Pages a captured 256-bit SHA-256 digest onto a 32-bit display word, one word at a time, under debounced next/prev buttons.
// Optional auto-scroll is compiled in with `define HASH_PAGER_AUTO_SCROLL_EN.

module hash_word_pager_debounce #(
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic clk_in,
   input  logic reset,
   input  logic btn_in,
   output logic step_pulse
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_PRESS_CNT = 2'd1,
      ST_HELD      = 2'd2,
      ST_REL_CNT   = 2'd3
   } db_state_t;

   db_state_t        state_r, state_nxt_s;
   logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
   logic             sync1_r, sync2_r;

   // Synchronizer, FSM state and stability counter registers
   always_ff @(posedge clk_in) begin
      if (reset) begin
         sync1_r <= 1'b0;
         sync2_r <= 1'b0;
         state_r <= ST_IDLE;
         cnt_r   <= '0;
      end else begin
         sync1_r <= btn_in;
         sync2_r <= sync1_r;
         state_r <= state_nxt_s;
         cnt_r   <= cnt_nxt_s;
      end
   end

   // Next-state logic: the level must stay put for DEBOUNCE_CYCLES before a transition is accepted
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      case (state_r)
         ST_IDLE: begin
            if (sync2_r) begin
               state_nxt_s = ST_PRESS_CNT;
               cnt_nxt_s   = '0;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_PRESS_CNT: begin
            if (!sync2_r) begin
               state_nxt_s = ST_IDLE;
               cnt_nxt_s   = '0;
            end else if (cnt_r == CNT_LAST) begin
               state_nxt_s = ST_HELD;
            end else begin
               cnt_nxt_s = cnt_r + CNT_W'(1);
            end
         end
         ST_HELD: begin
            if (!sync2_r) begin
               state_nxt_s = ST_REL_CNT;
               cnt_nxt_s   = '0;
            end else begin
               state_nxt_s = ST_HELD;
            end
         end
         ST_REL_CNT: begin
            if (sync2_r) begin
               state_nxt_s = ST_HELD;
            end else if (cnt_r == CNT_LAST) begin
               state_nxt_s = ST_IDLE;
            end else begin
               cnt_nxt_s = cnt_r + CNT_W'(1);
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
            cnt_nxt_s   = '0;
         end
      endcase
   end

   // Output logic: one pulse on the PRESS_CNT -> HELD transition only
   always_comb begin
      if ((state_r == ST_PRESS_CNT) && sync2_r && (cnt_r == CNT_LAST)) begin
         step_pulse = 1'b1;
      end else begin
         step_pulse = 1'b0;
      end
   end

endmodule

module hash_word_pager #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int SCROLL_CYCLES   = 200000000
) (
   input  logic         clk_in,
   input  logic         reset,
   input  logic [255:0] hash_in,
   input  logic         hash_valid,
   input  logic         btn_next_in,
   input  logic         btn_prev_in,
   output logic [31:0]  Word,
   output logic [2:0]   word_index,
   output logic         hash_loaded
);

   logic [255:0] capture_r, capture_nxt_s;
   logic [2:0]   index_r, index_nxt_s;
   logic [31:0]  word_r;
   logic         loaded_r, loaded_nxt_s;
   logic         next_step_s, prev_step_s, auto_step_s;

   function automatic logic [31:0] sel_word(input logic [255:0] cap, input logic [2:0] idx);
      case (idx)
         3'd0:    sel_word = cap[255:224];
         3'd1:    sel_word = cap[223:192];
         3'd2:    sel_word = cap[191:160];
         3'd3:    sel_word = cap[159:128];
         3'd4:    sel_word = cap[127:96];
         3'd5:    sel_word = cap[95:64];
         3'd6:    sel_word = cap[63:32];
         3'd7:    sel_word = cap[31:0];
         default: sel_word = cap[255:224];
      endcase
   endfunction

   hash_word_pager_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_next (
      .clk_in     (clk_in),
      .reset      (reset),
      .btn_in     (btn_next_in),
      .step_pulse (next_step_s)
   );

   hash_word_pager_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_prev (
      .clk_in     (clk_in),
      .reset      (reset),
      .btn_in     (btn_prev_in),
      .step_pulse (prev_step_s)
   );

`ifdef HASH_PAGER_AUTO_SCROLL_EN
   localparam int SCR_W = (SCROLL_CYCLES > 1) ? $clog2(SCROLL_CYCLES) : 1;
   localparam logic [SCR_W-1:0] SCR_LAST = SCR_W'(SCROLL_CYCLES - 1);

   logic [SCR_W-1:0] scroll_r, scroll_nxt_s;

   // Scroll counter next value: restarts on any user or hash event, idles at 0 until loaded
   always_comb begin
      if (hash_valid || next_step_s || prev_step_s) begin
         scroll_nxt_s = '0;
      end else if (!loaded_r) begin
         scroll_nxt_s = '0;
      end else if (scroll_r == SCR_LAST) begin
         scroll_nxt_s = '0;
      end else begin
         scroll_nxt_s = scroll_r + SCR_W'(1);
      end
   end

   // Scroll counter register
   always_ff @(posedge clk_in) begin
      if (reset) begin
         scroll_r <= '0;
      end else begin
         scroll_r <= scroll_nxt_s;
      end
   end

   assign auto_step_s = loaded_r && (scroll_r == SCR_LAST);
`else
   assign auto_step_s = 1'b0;
`endif

   // Index/capture next state; buttons outrank the implicit scroll step
   always_comb begin
      capture_nxt_s = capture_r;
      index_nxt_s   = index_r;
      loaded_nxt_s  = loaded_r;
      if (hash_valid) begin
         capture_nxt_s = hash_in;
         index_nxt_s   = 3'd0;
         loaded_nxt_s  = 1'b1;
      end else if (next_step_s && prev_step_s) begin
         index_nxt_s = index_r;
      end else if (next_step_s) begin
         index_nxt_s = index_r + 3'd1;
      end else if (prev_step_s) begin
         index_nxt_s = index_r - 3'd1;
      end else if (auto_step_s) begin
         index_nxt_s = index_r + 3'd1;
      end else begin
         index_nxt_s = index_r;
      end
   end

   // Output registers; Word is taken from next-state values so it moves with word_index
   always_ff @(posedge clk_in) begin
      if (reset) begin
         capture_r <= '0;
         index_r   <= 3'd0;
         loaded_r  <= 1'b0;
         word_r    <= 32'd0;
      end else begin
         capture_r <= capture_nxt_s;
         index_r   <= index_nxt_s;
         loaded_r  <= loaded_nxt_s;
         word_r    <= sel_word(capture_nxt_s, index_nxt_s);
      end
   end

   assign Word        = word_r;
   assign word_index  = index_r;
   assign hash_loaded = loaded_r;

endmodule
